// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared types and constants for the program-counter sequencer slice.
//   rd_kind_t : encoding of the redirect kind driven by the execute stage
//   state_t   : sequencer FSM states
//   PC_STEP   : byte distance between consecutive instruction words
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RD_NONE   = 2'b00,
        RD_BRANCH = 2'b01,
        RD_JUMP   = 2'b10,
        RD_JR     = 2'b11
    } rd_kind_t;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_sequencer_offset_scaler.sv
// offset_scaler
// Converts a signed 16-bit word offset into a byte offset of ADDR_W bits:
// sign-extend, then multiply by 4 (two zero bits appended).
// Ports:
//   imm16   in  16      signed word offset
//   scaled  out ADDR_W  sign-extended byte offset
module offset_scaler #(
    parameter int ADDR_W = 32
) (
    input  logic [15:0]       imm16,
    output logic [ADDR_W-1:0] scaled
);

    // Word offset becomes a byte offset by appending two zero bits; the
    // sign bit fills everything above the 18 meaningful bits.
    assign scaled = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Owns the program counter and drives instruction fetch. One fetch is issued per
// req_valid/req_ready handshake; redirects from execute (branch, jump, jr) replace
// the PC and squash the request raised in the same cycle.
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : jr to a non-word-aligned address goes to TRAP_VECTOR and pulses trap
//   undefined : jr target has its low two bits cleared, trap is held at 0
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   stall           suppress raising a new fetch request
//   halt            enter halt state (only reset leaves it)
//   rd_valid/kind   redirect strobe and kind (none/branch/jump/jr)
//   rd_pc           PC of the redirecting instruction
//   rd_imm16        signed branch word offset
//   rd_idx26        jump word index
//   rd_reg          jr byte target
//   req_valid/ready fetch handshake to instruction memory
//   pc              address of the current request
//   trap            one-cycle pulse after a misaligned jr (trap build only)
//   fetch_count     number of accepted requests, wraps at 2^32
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(32'h0000_0080)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              halt,
    input  logic              rd_valid,
    input  logic [1:0]        rd_kind,
    input  logic [ADDR_W-1:0] rd_pc,
    input  logic [15:0]       rd_imm16,
    input  logic [25:0]       rd_idx26,
    input  logic [ADDR_W-1:0] rd_reg,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              trap,
    output logic [31:0]       fetch_count
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       count_q;
    logic              pending;
    logic              trap_q;

    rd_kind_t          kind;
    logic              redirect;
    logic              accept;
    logic [ADDR_W-1:0] rd_pc_plus4;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic              jr_misaligned;
    logic [ADDR_W-1:0] target;

    assign kind     = rd_kind_t'(rd_kind);
    assign redirect = rd_valid && (kind != RD_NONE);

    // A request is shown while fetching unless halt or a redirect squashes it.
    // "pending" remembers an already-raised request so a late stall cannot
    // withdraw it; otherwise a new request appears only when stall is low.
    assign req_valid = (state == S_FETCH) && !halt && !redirect && (pending || !stall);
    assign accept    = req_valid && req_ready;

    offset_scaler #(.ADDR_W(ADDR_W)) u_offset_scaler (
        .imm16  (rd_imm16),
        .scaled (branch_off)
    );

    assign rd_pc_plus4 = rd_pc + STEP;
    assign branch_tgt  = rd_pc_plus4 + branch_off;
    assign jump_tgt    = {rd_pc_plus4[ADDR_W-1:28], rd_idx26, 2'b00};

    // With the trap disabled a misaligned jr is simply forced onto a word
    // boundary; with it enabled the aligned case is unchanged by the mask.
    assign jr_misaligned = TRAP_EN && (rd_reg[1:0] != 2'b00);
    assign jr_tgt        = jr_misaligned ? TRAP_VECTOR : (rd_reg & ALIGN_MASK);

    // Selects the redirect destination for the current rd_kind.
    always_comb begin
        target = pc_q;
        case (kind)
            RD_BRANCH: target = branch_tgt;
            RD_JUMP:   target = jump_tgt;
            RD_JR:     target = jr_tgt;
            default:   target = pc_q;
        endcase
    end

    // Sequencer state. Within S_FETCH the order halt > redirect > accept sets
    // which event owns the cycle; trap is a one-cycle pulse and defaults low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
            pending <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            trap_q <= 1'b0;
            case (state)
                S_BOOT: begin
                    state   <= S_FETCH;
                    pending <= 1'b0;
                end
                S_FETCH: begin
                    if (halt) begin
                        state   <= S_HALT;
                        pending <= 1'b0;
                    end else if (redirect) begin
                        pc_q    <= target;
                        pending <= 1'b0;
                        trap_q  <= (kind == RD_JR) && jr_misaligned;
                    end else if (accept) begin
                        pc_q    <= pc_q + STEP;
                        count_q <= count_q + 32'd1;
                        pending <= 1'b0;
                    end else begin
                        pending <= req_valid;
                    end
                end
                S_HALT: begin
                    pending <= 1'b0;
                end
                default: begin
                    state   <= S_BOOT;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign fetch_count = count_q;
    assign trap        = TRAP_EN ? trap_q : 1'b0;

endmodule
